switch_conditioner: RTL and testbench
=====================================

SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required before a debounced output changes; legal range 2..2^24-1.
REQ-002 SHALL have parameter RESET_HOLD_CYCLES, default 1000000: cycles CPURESET is held after a run request before RUN rises; legal range 2..2^24-1.
REQ-003 SHALL have port MCLK_IN, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port RST_IN, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port RUN_SW_IN, input, 1 bit: raw, asynchronous run switch, high = pressed/on.
REQ-006 SHALL have port STEP_SW_IN, input, 1 bit: raw, asynchronous step push-button, high = pressed.
REQ-007 SHALL have port STEPEN_SW_IN, input, 1 bit: raw, asynchronous step-mode enable switch, high = on.
REQ-008 SHALL have port RUN, output, 1 bit: the run enable consumed by the bus controller; low holds the bus controller in reset.
REQ-009 SHALL have port STEP, output, 1 bit: the debounced step level.
REQ-010 SHALL have port STEPEN, output, 1 bit: the debounced step-mode enable.
REQ-011 SHALL have port CPURESET, output, 1 bit: high requests assertion of the 68000 RESET/HALT lines.

Function
REQ-012 SHALL pass each raw switch through a two-flop synchronizer before any other use.
REQ-013 SHALL give each debouncer a counter that clears whenever the synchronized value equals the debounced value and otherwise increments.
REQ-014 SHALL, when the synchronized value differs from the debounced value and the counter equals DEBOUNCE_CYCLES-1, load the debounced value from the synchronized value and clear the counter; a single-cycle disagreement SHALL restart the count.
REQ-015 SHALL have a latency from a clean raw edge to the debounced output edge of exactly 2+DEBOUNCE_CYCLES clocks.
REQ-016 SHALL drive STEPEN as the debounced step-enable value.
REQ-017 SHALL drive STEP as the debounced step value AND STEPEN, so STEP is forced 0 whenever STEPEN is 0.
REQ-018 SHALL implement run-control FSM states STOPPED (RUN=0, CPURESET=1), STARTING (RUN=0, CPURESET=1) and RUNNING (RUN=1, CPURESET=0); RUN and CPURESET SHALL be registered.
REQ-019 SHALL transition STOPPED->STARTING on a run request (see REQ-025/026) and clear the hold counter.
REQ-020 SHALL increment the hold counter in STARTING and enter RUNNING when it equals RESET_HOLD_CYCLES-1, so RUN rises exactly RESET_HOLD_CYCLES clocks after STARTING is entered.
REQ-021 SHALL, on a stop request in STARTING or RUNNING, enter STOPPED on the next clock, taking priority over hold-counter completion in the same cycle.
REQ-022 SHALL never drive RUN=1 and CPURESET=1 in the same cycle.

Reset
REQ-023 SHALL, on RST_IN=1 at a clock edge, clear all synchronizer flops, debounced values and counters to 0 and enter STOPPED (RUN=0, STEP=0, STEPEN=0, CPURESET=1).
REQ-024 SHALL, on RST_IN asserted mid-STARTING or mid-RUNNING, abandon the sequence; a restart SHALL require a fresh run request and a full RESET_HOLD_CYCLES hold.

Configuration
REQ-025 SHALL, with macro RUN_TOGGLE_EN defined, treat RUN_SW_IN as a momentary button: a debounced rising edge in STOPPED is a run request, and one in STARTING or RUNNING is a stop request; level and falling edges are ignored.
REQ-026 SHALL, without RUN_TOGGLE_EN, treat RUN_SW_IN as a latching switch: a debounced level of 1 in STOPPED is a run request, and a level of 0 in STARTING or RUNNING is a stop request.

Structure
REQ-027 SHALL place the FSM state typedef (STOPPED/STARTING/RUNNING) and the counter width constant (24) in the shared package switch_conditioner_pkg.
REQ-028 SHALL implement the synchronizer plus debouncer as sub-module switch_debounce, parameterized by DEBOUNCE_CYCLES and instantiated three times.

Verification
REQ-029 SHALL cover, with DEBOUNCE_CYCLES=4: a raw STEPEN_SW_IN 0->1 held steady -> STEPEN rises exactly 6 clocks later.
REQ-030 SHALL cover, with DEBOUNCE_CYCLES=4: STEPEN_SW_IN toggled every 2 clocks for 40 clocks -> STEPEN never changes.
REQ-031 SHALL cover, with STEPEN=0: STEP_SW_IN held 1 for 20 clocks -> STEP stays 0; then with STEPEN=1 -> STEP=1 after 6 clocks.
REQ-032 SHALL cover, with RESET_HOLD_CYCLES=8 and no RUN_TOGGLE_EN: a RUN_SW_IN 0->1 -> CPURESET stays 1 and RUN stays 0 until RUN rises exactly 8 clocks after STARTING entry, with CPURESET falling on the same clock; RUN_SW_IN then 1->0 -> RUN=0 and CPURESET=1 after 2+DEBOUNCE_CYCLES+1 clocks.
REQ-033 SHALL cover RST_IN pulsed for 1 clock during RUNNING -> next cycle RUN=0, CPURESET=1, STEP=0, STEPEN=0.
REQ-034 SHALL cover, with RUN_TOGGLE_EN: two separate presses of RUN_SW_IN -> the first press starts the sequence and the second stops it; holding the button SHALL produce no re-toggle.

Source files
------------

// File: rtl/switch_conditioner_pkg.sv
// Shared definitions for the front-panel switch conditioner: counter width
// and the run-control state encoding.
package switch_conditioner_pkg;

  // Width of the debounce and reset-hold counters.
  localparam int unsigned CNT_W = 24;

  // Run-control states.
  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    STARTING = 2'd1,
    RUNNING  = 2'd2
  } run_state_e;

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchronizer followed by a counting debouncer for one raw switch.
// The debounced value follows the synchronized value only after it has
// disagreed for DEBOUNCE_CYCLES consecutive clocks; any agreement restarts
// the count.
module switch_debounce
  import switch_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic raw_i,
  output logic deb_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Debounce decision: count disagreement, load on the final count.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync_q[1];
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, debounced value and counter registers.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sync_q <= '0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/switch_conditioner.sv
// Front-panel switch conditioner: debounces the run, step and step-enable
// switches and sequences the 68000 reset hold before enabling the bus
// controller.
// Optional macro RUN_TOGGLE_EN: run switch acts as a momentary start/stop
// button instead of a latching on/off switch.
module switch_conditioner
  import switch_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 50000,
  parameter int unsigned RESET_HOLD_CYCLES = 1000000
) (
  input  logic MCLK_IN,
  input  logic RST_IN,
  input  logic RUN_SW_IN,
  input  logic STEP_SW_IN,
  input  logic STEPEN_SW_IN,
  output logic RUN,
  output logic STEP,
  output logic STEPEN,
  output logic CPURESET
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);

  // Bit 0 = run, bit 1 = step, bit 2 = step enable.
  logic [2:0] raw_sw;
  logic [2:0] deb_sw;

  assign raw_sw = {STEPEN_SW_IN, STEP_SW_IN, RUN_SW_IN};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_deb
      switch_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk_i (MCLK_IN),
        .srst_i(RST_IN),
        .raw_i (raw_sw[gi]),
        .deb_o (deb_sw[gi])
      );
    end
  endgenerate

  logic run_req;
  logic stop_req;

`ifdef RUN_TOGGLE_EN
  logic run_prev_q;

  // Remember last debounced run level for rising-edge detection.
  always_ff @(posedge MCLK_IN) begin
    if (RST_IN) begin
      run_prev_q <= 1'b0;
    end else begin
      run_prev_q <= deb_sw[0];
    end
  end

  // Each press toggles: the same edge starts from STOPPED and stops otherwise.
  assign run_req  = deb_sw[0] & ~run_prev_q;
  assign stop_req = deb_sw[0] & ~run_prev_q;
`else
  // Latching switch: level selects run or stop.
  assign run_req  = deb_sw[0];
  assign stop_req = ~deb_sw[0];
`endif

  run_state_e       state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             run_q, run_d;
  logic             cpureset_q, cpureset_d;

  // Run-control next state; stop beats hold completion in the same cycle.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      STOPPED: begin
        if (run_req) begin
          state_d = STARTING;
          hold_d  = '0;
        end
      end
      STARTING: begin
        hold_d = hold_q + 1'b1;
        if (stop_req) begin
          state_d = STOPPED;
        end else if (hold_q == HOLD_LAST) begin
          state_d = RUNNING;
        end
      end
      RUNNING: begin
        if (stop_req) begin
          state_d = STOPPED;
        end
      end
      default: begin
        state_d = STOPPED;
      end
    endcase
    // Outputs are decoded from the next state so they register with it.
    run_d      = (state_d == RUNNING);
    cpureset_d = ~run_d;
  end

  // Run-control state, hold counter and registered outputs.
  always_ff @(posedge MCLK_IN) begin
    if (RST_IN) begin
      state_q    <= STOPPED;
      hold_q     <= '0;
      run_q      <= 1'b0;
      cpureset_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      run_q      <= run_d;
      cpureset_q <= cpureset_d;
    end
  end

  assign RUN      = run_q;
  assign CPURESET = cpureset_q;
  assign STEPEN   = deb_sw[2];
  assign STEP     = deb_sw[1] & deb_sw[2];

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner with DEBOUNCE_CYCLES=4, RESET_HOLD_CYCLES=8.
// A behavioural model predicts all outputs every cycle; directed checks pin
// the key latencies with literal values.
module tb_switch_conditioner;

  localparam int D = 4;
  localparam int H = 8;

  logic MCLK_IN      = 1'b0;
  logic RST_IN       = 1'b1;
  logic RUN_SW_IN    = 1'b0;
  logic STEP_SW_IN   = 1'b0;
  logic STEPEN_SW_IN = 1'b0;
  logic RUN, STEP, STEPEN, CPURESET;

  int total = 0;
  int bad   = 0;

  always #5 MCLK_IN = ~MCLK_IN;

  switch_conditioner #(
    .DEBOUNCE_CYCLES  (D),
    .RESET_HOLD_CYCLES(H)
  ) dut (
    .MCLK_IN     (MCLK_IN),
    .RST_IN      (RST_IN),
    .RUN_SW_IN   (RUN_SW_IN),
    .STEP_SW_IN  (STEP_SW_IN),
    .STEPEN_SW_IN(STEPEN_SW_IN),
    .RUN         (RUN),
    .STEP        (STEP),
    .STEPEN      (STEPEN),
    .CPURESET    (CPURESET)
  );

  // ---------------- behavioural model ----------------
  // Raw samples since reset (last two kept) and the synchronized samples
  // (last D kept). A debounced bit adopts a value once the last D
  // synchronized samples all hold it.
  logic [2:0] raw_hist[$];
  logic [2:0] sync_hist[$];
  logic [2:0] deb_m = 3'b000;
  logic       run_prev_m = 1'b0;
  int         phase_m = 0;   // 0 stopped, 1 starting, 2 running
  int         elapsed_m = 0; // clocks spent in starting
  bit         model_valid = 0;
  logic       exp_run = 1'b0, exp_cpureset = 1'b1, exp_step = 1'b0, exp_stepen = 1'b0;

  always @(posedge MCLK_IN) begin
    logic [2:0] raw_now;
    logic [2:0] sync_now;
    bit req, stop, all_same;
    raw_now = {STEPEN_SW_IN, STEP_SW_IN, RUN_SW_IN};
    if (RST_IN) begin
      raw_hist.delete();
      sync_hist.delete();
      deb_m      = 3'b000;
      run_prev_m = 1'b0;
      phase_m    = 0;
      elapsed_m  = 0;
    end else begin
      sync_now = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size() - 2] : 3'b000;
      raw_hist.push_back(raw_now);
      if (raw_hist.size() > 2) void'(raw_hist.pop_front());
`ifdef RUN_TOGGLE_EN
      req  = deb_m[0] && !run_prev_m;
      stop = req;
`else
      req  = deb_m[0];
      stop = !deb_m[0];
`endif
      run_prev_m = deb_m[0];
      case (phase_m)
        0: if (req) begin phase_m = 1; elapsed_m = 0; end
        1: begin
          if (stop) phase_m = 0;
          else begin
            elapsed_m++;
            if (elapsed_m == H) phase_m = 2;
          end
        end
        default: if (stop) phase_m = 0;
      endcase
      sync_hist.push_back(sync_now);
      if (sync_hist.size() > D) void'(sync_hist.pop_front());
      if (sync_hist.size() == D) begin
        for (int b = 0; b < 3; b++) begin
          all_same = 1;
          for (int k = 1; k < D; k++)
            if (sync_hist[k][b] != sync_hist[0][b]) all_same = 0;
          if (all_same) deb_m[b] = sync_hist[0][b];
        end
      end
    end
    exp_run      = (phase_m == 2);
    exp_cpureset = (phase_m != 2);
    exp_stepen   = deb_m[2];
    exp_step     = deb_m[1] & deb_m[2];
    model_valid  = 1;
  end

  // Compare every cycle on the falling edge.
  always @(negedge MCLK_IN) begin
    if (model_valid) begin
      total++;
      if ({RUN, CPURESET, STEP, STEPEN} !== {exp_run, exp_cpureset, exp_step, exp_stepen}) begin
        bad++;
        $display("FAIL model_cmp t=%0t run/cpureset/step/stepen got=%b%b%b%b want=%b%b%b%b",
                 $time, RUN, CPURESET, STEP, STEPEN, exp_run, exp_cpureset, exp_step, exp_stepen);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge MCLK_IN);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    $display("txn: reset");
    RST_IN = 1'b1;
    cyc(3);
    chk("reset_run", RUN, 1'b0);
    chk("reset_cpureset", CPURESET, 1'b1);
    chk("reset_step", STEP, 1'b0);
    chk("reset_stepen", STEPEN, 1'b0);
    RST_IN = 1'b0;

    $display("txn: stepen chatter every 2 clocks for 40 clocks");
    for (int i = 0; i < 20; i++) begin
      STEPEN_SW_IN = ~STEPEN_SW_IN;
      cyc(2);
      chk("chatter_stepen", STEPEN, 1'b0);
    end
    cyc(8);
    chk("chatter_settled", STEPEN, 1'b0);

    $display("txn: step held with stepen off");
    STEP_SW_IN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("step_gated", STEP, 1'b0);
    end

    $display("txn: stepen 0->1, expect rise after 6 clocks");
    STEPEN_SW_IN = 1'b1;
    cyc(5);
    chk("stepen_lat5", STEPEN, 1'b0);
    chk("step_lat5", STEP, 1'b0);
    cyc(1);
    chk("stepen_lat6", STEPEN, 1'b1);
    chk("step_lat6", STEP, 1'b1);
    chk("model_pin_stepen", exp_stepen, 1'b1);

    $display("txn: step release");
    STEP_SW_IN = 1'b0;
    cyc(5);
    chk("step_rel5", STEP, 1'b1);
    cyc(1);
    chk("step_rel6", STEP, 1'b0);

`ifndef RUN_TOGGLE_EN
    $display("txn: run switch on, expect RUN after 2+D+1+H clocks");
    RUN_SW_IN = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      cyc(1);
      chk("hold_run", RUN, 1'b0);
      chk("hold_cpureset", CPURESET, 1'b1);
    end
    cyc(1);
    chk("run_rise", RUN, 1'b1);
    chk("cpureset_fall", CPURESET, 1'b0);
    chk("model_pin_run", exp_run, 1'b1);
    cyc(10);
    chk("run_steady", RUN, 1'b1);

    $display("txn: run switch off, expect stop after 7 clocks");
    RUN_SW_IN = 1'b0;
    cyc(6);
    chk("stop_lat6", RUN, 1'b1);
    cyc(1);
    chk("stop_run", RUN, 1'b0);
    chk("stop_cpureset", CPURESET, 1'b1);
    chk("model_pin_stop", exp_cpureset, 1'b1);

    $display("txn: reset pulse while running");
    STEP_SW_IN = 1'b1;
    RUN_SW_IN  = 1'b1;
    cyc(15);
    chk("pre_rst_run", RUN, 1'b1);
    chk("pre_rst_step", STEP, 1'b1);
    RST_IN = 1'b1;
    cyc(1);
    RST_IN = 1'b0;
    chk("rst_run", RUN, 1'b0);
    chk("rst_cpureset", CPURESET, 1'b1);
    chk("rst_step", STEP, 1'b0);
    chk("rst_stepen", STEPEN, 1'b0);

    $display("txn: restart after reset needs full hold");
    cyc(13);
    cyc(1);
    chk("restart_14", RUN, 1'b0);
    cyc(1);
    chk("restart_15", RUN, 1'b1);
`else
    $display("txn: first press starts the sequence");
    RUN_SW_IN = 1'b1;
    cyc(14);
    chk("tog_hold_run", RUN, 1'b0);
    chk("tog_hold_cpureset", CPURESET, 1'b1);
    cyc(1);
    chk("tog_run_rise", RUN, 1'b1);
    chk("model_pin_run", exp_run, 1'b1);
    cyc(20);
    chk("tog_held_no_retoggle", RUN, 1'b1);
    RUN_SW_IN = 1'b0;
    cyc(10);
    chk("tog_release_ignored", RUN, 1'b1);

    $display("txn: second press stops");
    RUN_SW_IN = 1'b1;
    cyc(6);
    chk("tog_stop_lat6", RUN, 1'b1);
    cyc(1);
    chk("tog_stop_run", RUN, 1'b0);
    chk("tog_stop_cpureset", CPURESET, 1'b1);
    cyc(20);
    chk("tog_stop_held", RUN, 1'b0);
    RUN_SW_IN = 1'b0;
    cyc(10);
    chk("tog_stop_released", RUN, 1'b0);

    $display("txn: reset pulse while running");
    STEP_SW_IN = 1'b1;
    RUN_SW_IN  = 1'b1;
    cyc(15);
    chk("pre_rst_run", RUN, 1'b1);
    chk("pre_rst_step", STEP, 1'b1);
    RUN_SW_IN = 1'b0;
    cyc(2);
    RST_IN = 1'b1;
    cyc(1);
    RST_IN = 1'b0;
    chk("rst_run", RUN, 1'b0);
    chk("rst_cpureset", CPURESET, 1'b1);
    chk("rst_step", STEP, 1'b0);
    chk("rst_stepen", STEPEN, 1'b0);
    cyc(20);
    chk("rst_no_restart", RUN, 1'b0);
`endif

    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
